vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Timing generator and pixel output stage for 640x480@60 VGA; the producing end of the pixel_x/pixel_y interface that the background and sprite renderers consume.
- Derives the pixel tick from the system clock, runs the horizontal and vertical counters, and exposes the current pixel coordinates.
- Takes back the combinational rgb from the renderers, blanks it outside the visible area, and registers it together with hsync/vsync so colour and sync stay aligned at the connector.

Parameters:
- DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel); legal values ≥ 2
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_DISP, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rgb_in  in  3  colour for current pixel_x/pixel_y, combinational from renderers
- test_mode  in  1  select test pattern (used only with VGA_TEST_PATTERN_EN)
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  pixel_x<H_DISP && pixel_y<V_DISP, combinational from counters
- p_tick  out  1  one-clk pulse per pixel period
- frame_tick  out  1  one-clk pulse at end of frame
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- rgb_out  out  3  registered, blanked colour to DAC

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Derived constants: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Pixel divider:
  - div_cnt counts 0..DIV-1 and wraps.
  - p_tick = (div_cnt == DIV-1).
  - After reset, the first p_tick occurs on clock DIV-1.
- Horizontal counter: advances only on p_tick; wraps H_TOTAL-1 -> 0.
- Vertical counter: advances only on a p_tick that wraps the horizontal counter; wraps V_TOTAL-1 -> 0 in the same clock as that horizontal wrap.
- frame_tick: p_tick && h==H_TOTAL-1 && v==V_TOTAL-1. Combinational, high exactly one clk per frame, coincident with the clk that wraps both counters.
- Output stage (on p_tick only, otherwise hold):
  - hsync <= ~(h ≥ H_DISP+H_FP && h < H_DISP+H_FP+H_SYNC)
  - vsync <= ~(v ≥ V_DISP+V_FP && v < V_DISP+V_FP+V_SYNC)
  - rgb_out <= video_on ? colour : 3'b000
  - Result: hsync, vsync and rgb_out all lag pixel_x/pixel_y by exactly one pixel period, and stay aligned with each other.
- Reset values:
  - div_cnt = 0, h = 0, v = 0
  - hsync = 1, vsync = 1, rgb_out = 000
  - p_tick = 0 (if DIV>1), frame_tick = 0
  - video_on = 1 (follows counters at 0,0)
- Reset mid-frame: all of the above take effect on the next clk edge. No partial line is emitted; timing restarts at (0,0).
- Width rules:
  - Counters are 10 bits; H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024 are required.
  - Comparisons are unsigned.
- rgb_in must settle within one clk of pixel_x/pixel_y changing. Counters are stable for DIV clks, so a DIV ≥ 2 pipeline budget applies to renderers.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when test_mode=1, colour = pixel_x[9:7] (8 vertical bars, 128 px wide, 000..100 visible); otherwise colour = rgb_in. Blanking still applies.
- Undefined: colour = rgb_in always; test_mode is unused and synthesises away.

Decomposition:
- Shared package/header: VGA timing constants (H_*/V_* defaults), the colour localparams used by renderers (NEGRO=000 … BLANCO=111), and the 3-bit rgb width.
- One natural sub-module: vga_pixel_div (div_cnt and p_tick), reusable by renderers that need a pixel-rate scroll enable.
- Counters and the output stage remain in vga_sync.

Test Plan:
- Reset then free-run, DIV=2 -> p_tick every 2 clk starting clk 1; frame_tick period exactly 800*525*2 = 840000 clk.
- Line timing -> hsync low for exactly 96 p_ticks, falling edge one pixel after pixel_x goes 655->656; high again one pixel after 751->752.
- Frame timing -> vsync low for exactly 2 lines, asserted one pixel after pixel_y reaches 490, released one pixel after pixel_y reaches 492.
- rgb_in=111 constant -> rgb_out=111 only in the pixel period after video_on=1; rgb_out=000 one pixel after pixel_x reaches 640 and throughout lines 480..524.
- Assert reset for 1 clk at pixel (300,200) -> next clk: pixel_x=0, pixel_y=0, hsync=1, vsync=1, rgb_out=000; subsequent frame_tick exactly 840000 clk after reset release.
- With VGA_TEST_PATTERN_EN, test_mode=1, rgb_in=000 -> rgb_out=011 one pixel after pixel_x=400 on line 10; rgb_out=000 one pixel after pixel_x=700.

Source files
------------

// File: rtl/vga_sync_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, renderer colour codes, rgb width.
// Optional test-pattern source in vga_sync is enabled by defining VGA_TEST_PATTERN_EN.
package vga_sync_pkg;

  localparam int RGB_W = 3;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam int H_DISP_DEF = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_DISP_DEF = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam rgb_t NEGRO    = 3'b000;
  localparam rgb_t AZUL     = 3'b001;
  localparam rgb_t VERDE    = 3'b010;
  localparam rgb_t CIAN     = 3'b011;
  localparam rgb_t ROJO     = 3'b100;
  localparam rgb_t MAGENTA  = 3'b101;
  localparam rgb_t AMARILLO = 3'b110;
  localparam rgb_t BLANCO   = 3'b111;

  // Half-open window test on a 10-bit counter: lo <= c < hi.
  function automatic logic in_window(logic [9:0] c, logic [9:0] lo, logic [9:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel-rate enable: one-clock p_tick_o every DIV system clocks, first on clock DIV-1 after reset.
module vga_pixel_div #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic p_tick_o
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign p_tick_o = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator and registered, blanked pixel output stage.
// Define VGA_TEST_PATTERN_EN to let test_mode replace rgb_in with 8 vertical colour bars.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int DIV    = 2,
  parameter int H_DISP = H_DISP_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  rgb_t       rgb_in,
  input  logic       test_mode,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output rgb_t       rgb_out
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_DISP);
  localparam logic [9:0] V_VIS   = 10'(V_DISP);
  localparam logic [9:0] HS_LO   = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_HI   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO   = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_HI   = 10'(V_DISP + V_FP + V_SYNC);
  localparam logic [9:0] CNT_ONE = 10'd1;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  rgb_t       rgb_q, rgb_d;
  rgb_t       colour;
  logic       h_last, v_last;

  vga_pixel_div #(
    .DIV (DIV)
  ) u_pixel_div (
    .clk_i    (clk),
    .reset_i  (reset),
    .p_tick_o (p_tick)
  );

`ifdef VGA_TEST_PATTERN_EN
  assign colour = test_mode ? rgb_t'(h_q[9:7]) : rgb_in;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign colour           = rgb_in;
`endif

  assign h_last   = (h_q == H_LAST);
  assign v_last   = (v_q == V_LAST);
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (p_tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CNT_ONE;
      end else begin
        h_d = h_q + CNT_ONE;
      end
      // Sync and colour describe the pixel just finished, so they lag the counters by one pixel.
      hsync_d = ~in_window(h_q, HS_LO, HS_HI);
      vsync_d = ~in_window(v_q, VS_LO, VS_HI);
      rgb_d   = video_on ? colour : NEGRO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= NEGRO;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign frame_tick = p_tick && h_last && v_last;
  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync on a reduced 35x19-pixel raster so several frames fit in a short run.
// Expected outputs come from clocks-since-reset arithmetic; literal checks pin that model.
module tb_vga_sync;
  import vga_sync_pkg::*;

  localparam int DIV = 2;
  localparam int HD = 20, HFP = 4, HS = 6, HBP = 5;
  localparam int VD = 10, VFP = 3, VS = 2, VBP = 4;
  localparam int HT = 35;
  localparam int VT = 19;
  localparam int FRAME = 1330;
  localparam int BUDGET = 2 * FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  rgb_t       rgb_in;
  logic       test_mode;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, p_tick, frame_tick, hsync, vsync;
  rgb_t       rgb_out;

  int total = 0;
  int bad   = 0;

  int t        = 0;
  bit valid    = 1'b0;
  int mode     = 0;
  int cur_mode = 0;

  always #5 clk = ~clk;

  vga_sync #(
    .DIV(DIV), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rgb_in     (rgb_in),
    .test_mode  (test_mode),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .p_tick     (p_tick),
    .frame_tick (frame_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_out    (rgb_out)
  );

  // Renderer stand-in: colour as a function of the pixel the model says is current.
  function automatic rgb_t pat(int md, int h, int v);
    case (md)
      0:       return 3'b111;
      1:       return 3'((h + 3 * v) % 8);
      default: return 3'(((h * 5) ^ v) % 8);
    endcase
  endfunction

  function automatic rgb_t colour_of(int md, int h, int v);
`ifdef VGA_TEST_PATTERN_EN
    if (md == 2) return 3'((h / 128) % 8);
`endif
    return pat(md, h, v);
  endfunction

  assign test_mode = (cur_mode == 2);
  assign rgb_in    = pat(cur_mode, (t / DIV) % HT, ((t / DIV) / HT) % VT);

  always @(posedge clk) begin
    if (reset) begin
      t        <= 0;
      valid    <= 1'b1;
      cur_mode <= mode;
    end else begin
      t <= t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int   n, h, v, m, hm, vm;
    logic ept, eft, evid, ehs, evs;
    rgb_t ergb;
    if (valid) begin
      n    = t / DIV;
      h    = n % HT;
      v    = (n / HT) % VT;
      ept  = (t % DIV) == DIV - 1;
      eft  = ept && h == HT - 1 && v == VT - 1;
      evid = h < HD && v < VD;
      if (n == 0) begin
        ehs  = 1'b1;
        evs  = 1'b1;
        ergb = 3'b000;
      end else begin
        m    = n - 1;
        hm   = m % HT;
        vm   = (m / HT) % VT;
        ehs  = !(hm >= HD + HFP && hm < HD + HFP + HS);
        evs  = !(vm >= VD + VFP && vm < VD + VFP + VS);
        ergb = (hm < HD && vm < VD) ? colour_of(cur_mode, hm, vm) : 3'b000;
      end
      chk("pixel_x", 32'(pixel_x), 32'(h));
      chk("pixel_y", 32'(pixel_y), 32'(v));
      chk("p_tick", 32'(p_tick), 32'(ept));
      chk("frame_tick", 32'(frame_tick), 32'(eft));
      chk("video_on", 32'(video_on), 32'(evid));
      chk("hsync", 32'(hsync), 32'(ehs));
      chk("vsync", 32'(vsync), 32'(evs));
      chk("rgb_out", 32'(rgb_out), 32'(ergb));
    end
  end

  initial begin
    int cnt;
    mode = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pixel_x", 32'(pixel_x), 0);
    chk("rst_pixel_y", 32'(pixel_y), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_video_on", 32'(video_on), 1);
    chk("rst_p_tick", 32'(p_tick), 0);
    chk("rst_frame_tick", 32'(frame_tick), 0);
    @(negedge clk);
    chk("first_p_tick", 32'(p_tick), 1);
    @(negedge clk);
    chk("second_clk_x", 32'(pixel_x), 1);

    cnt = 0;
    while (hsync !== 1'b0 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("hs_fall_timeout", 32'(cnt < BUDGET), 1);
    chk("hs_fall_x", 32'(pixel_x), 25);
    cnt = 0;
    while (hsync === 1'b0 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("hs_low_clks", 32'(cnt), 12);
    chk("hs_rise_x", 32'(pixel_x), 31);

    cnt = 0;
    while (vsync !== 1'b0 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("vs_fall_timeout", 32'(cnt < BUDGET), 1);
    chk("vs_fall_y", 32'(pixel_y), 13);
    chk("vs_fall_x", 32'(pixel_x), 1);
    cnt = 0;
    while (vsync === 1'b0 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("vs_low_clks", 32'(cnt), 140);
    chk("vs_rise_y", 32'(pixel_y), 15);
    chk("vs_rise_x", 32'(pixel_x), 1);

    cnt = 0;
    while (rgb_out !== 3'b111 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("rgb_on_timeout", 32'(cnt < BUDGET), 1);
    chk("rgb_on_x", 32'(pixel_x), 1);
    chk("rgb_on_y", 32'(pixel_y), 0);
    cnt = 0;
    while (rgb_out !== 3'b000 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("rgb_off_x", 32'(pixel_x), 21);

    cnt = 0;
    while (frame_tick !== 1'b1 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("ft_timeout", 32'(cnt < BUDGET), 1);
    chk("ft_x", 32'(pixel_x), HT - 1);
    chk("ft_y", 32'(pixel_y), VT - 1);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (frame_tick !== 1'b1 && cnt < BUDGET);
    chk("ft_period", 32'(cnt), FRAME);

    mode = 1;
    cnt = 0;
    while (!(pixel_x == 10'd13 && pixel_y == 10'd5) && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("mid_wait_timeout", 32'(cnt < BUDGET), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_x", 32'(pixel_x), 0);
    chk("mid_rst_y", 32'(pixel_y), 0);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_vsync", 32'(vsync), 1);
    chk("mid_rst_rgb", 32'(rgb_out), 0);
    cnt = 0;
    while (frame_tick !== 1'b1 && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("ft_after_reset", 32'(cnt), FRAME - 1);

    cnt = 0;
    while (!(pixel_x == 10'd5 && pixel_y == 10'd2) && cnt < BUDGET) begin @(negedge clk); cnt++; end
    chk("mode1_rgb_5_2", 32'(rgb_out), 2);

    mode = 2;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (!(pixel_x == 10'd5 && pixel_y == 10'd2) && cnt < BUDGET) begin @(negedge clk); cnt++; end
`ifdef VGA_TEST_PATTERN_EN
    chk("testpat_rgb_5_2", 32'(rgb_out), 0);
`else
    chk("testmode_ignored_5_2", 32'(rgb_out), 6);
`endif
    repeat (3 * HT * DIV) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
